instr_sequencer: RTL and testbench

Fetch/issue controller for the 4-bit-opcode, two-3-bit-argument CPU. It owns the program counter and reads instruction words from program memory over a valid handshake. It presents one instruction at a time to the CPU control FSM and advances when that FSM pulses `done`. It also handles PC writes from the datapath, a HALT opcode, skipping of undefined opcodes, and a watchdog against a stalled control FSM.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/issue_watchdog.sv | 27 ++
 rtl/instr_sequencer.sv | 162 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, register and sequencer definitions for the CPU
package cpu_pkg;

    localparam int OP_W = 4;

    // Control-FSM opcodes; everything from 0100 to 1110 is undefined
    localparam logic [OP_W-1:0] OP_MOVE = 4'b0000;
    localparam logic [OP_W-1:0] OP_LOAD = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_NOP  = 4'b1110;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    // Word shown to the control FSM when nothing is issued; its undefined
    // opcode parks that FSM in its idle state
    localparam logic [9:0] NOP_WORD = {OP_NOP, 6'b0};

    // Register-file codes; code 7 addresses the program counter
    typedef enum logic [2:0] {
        R0     = 3'd0,
        R1     = 3'd1,
        R2     = 3'd2,
        R3     = 3'd3,
        R4     = 3'd4,
        R5     = 3'd5,
        R6     = 3'd6,
        REG_PC = 3'd7
    } reg_code_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        HALTED = 3'd3,
        FAULT  = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        OPC_EXEC  = 2'd0,
        OPC_HALT  = 2'd1,
        OPC_UNDEF = 2'd2
    } op_class_e;

    // Sort a fetched opcode into issue / stop / skip
    function automatic op_class_e classify_op(input logic [OP_W-1:0] op);
        if (op[3:2] == 2'b00) begin
            return OPC_EXEC;
        end else if (op == OP_HALT) begin
            return OPC_HALT;
        end else begin
            return OPC_UNDEF;
        end
    endfunction

endpackage

// File: rtl/issue_watchdog.sv
// rtl/issue_watchdog.sv - counts stalled ISSUE cycles and flags the last allowed one
module issue_watchdog #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;

    // Stall counter: zeroed whenever the sequencer is outside ISSUE
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (count_en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // High during the TIMEOUT-th stalled cycle so the fault lands on the next edge
    assign expired_o = count_en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program counter, instruction fetch and issue control
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int OP_SIZE  = 4,
    parameter int ARG_SIZE = 3,
    parameter int ARG_NUM  = 2,
    parameter int ADDR_W   = 8,
    parameter int END_ADDR = 255,
    parameter int TIMEOUT  = 15
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  run,
    input  logic                                  halt_req,
    output logic                                  mem_rd,
    output logic [ADDR_W-1:0]                     mem_addr,
    input  logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0]   mem_data,
    input  logic                                  mem_valid,
    output logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0]   instr,
    output logic                                  instr_valid,
    input  logic                                  done,
    input  logic                                  pc_load,
    input  logic [ADDR_W-1:0]                     pc_load_val,
    output logic [ADDR_W-1:0]                     pc,
    output logic                                  busy,
    output logic                                  halted,
    output logic                                  fault,
    output logic [15:0]                           retired
);

    localparam int INSTR_W = OP_SIZE + ARG_NUM * ARG_SIZE;
    localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, {(INSTR_W - OP_W){1'b0}}};
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(END_ADDR);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [15:0]        retired_q, retired_d;
    logic               pending_halt_q, pending_halt_d;

    logic               wd_clear;
    logic               wd_count_en;
    logic               wd_expired;
    op_class_e          fetched_class;

    assign fetched_class = classify_op(mem_data[INSTR_W-1 -: OP_SIZE]);

    assign wd_clear    = (state_q != ISSUE);
    assign wd_count_en = (state_q == ISSUE) && !done;

    issue_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (wd_clear),
        .count_en_i (wd_count_en),
        .expired_o  (wd_expired)
    );

    // Next-state decode for the sequencer state, PC, IR, retire count and stop request
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        retired_d      = retired_q;
        pending_halt_d = pending_halt_q;

        case (state_q)
            IDLE: begin
                if (run && !halt_req) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (halt_req) begin
                    pending_halt_d = 1'b1;
                end
                if (mem_valid) begin
                    case (fetched_class)
                        OPC_EXEC: begin
                            ir_d    = mem_data;
                            state_d = ISSUE;
                        end
                        OPC_HALT: begin
                            state_d        = HALTED;
                            pending_halt_d = 1'b0;
                        end
                        default: begin
                            // Undefined word: step over it without issuing
                            pc_d = pc_q + ADDR_W'(1);
                        end
                    endcase
                end
            end

            ISSUE: begin
                if (halt_req) begin
                    pending_halt_d = 1'b1;
                end
                if (done) begin
                    pc_d = pc_load ? pc_load_val : pc_q + ADDR_W'(1);
                    if (retired_q != 16'hFFFF) begin
                        retired_d = retired_q + 16'd1;
                    end
                    if (pending_halt_q || (pc_q == LAST_ADDR && !pc_load)) begin
                        state_d        = HALTED;
                        pending_halt_d = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end

            HALTED: begin
                if (run) begin
                    state_d = FETCH;
                end
            end

            FAULT: begin
                state_d = FAULT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state register; reset discards any fetch in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pc_q           <= '0;
            ir_q           <= '0;
            retired_q      <= '0;
            pending_halt_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            retired_q      <= retired_d;
            pending_halt_q <= pending_halt_d;
        end
    end

    assign mem_rd      = (state_q == FETCH);
    assign mem_addr    = pc_q;
    assign instr_valid = (state_q == ISSUE);
    assign instr       = instr_valid ? ir_q : NOP_INSTR;
    assign pc          = pc_q;
    assign busy        = (state_q == FETCH) || (state_q == ISSUE);
    assign halted      = (state_q == HALTED);
    assign fault       = (state_q == FAULT);
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        halt_req;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [9:0]  mem_data;
    logic        mem_valid;
    logic [9:0]  instr;
    logic        instr_valid;
    logic        done;
    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    logic [9:0]  mem [256];
    int          n_checks;
    int          n_pass;
    int          mem_lat;

    instr_sequencer #(
        .OP_SIZE  (4),
        .ARG_SIZE (3),
        .ARG_NUM  (2),
        .ADDR_W   (8),
        .END_ADDR (255),
        .TIMEOUT  (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .halt_req    (halt_req),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .done        (done),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .retired     (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program memory: answers a read request after mem_lat FETCH cycles
    initial begin
        int cnt;
        cnt       = 0;
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            if (rst || !mem_rd) begin
                cnt       = 0;
                mem_valid = 1'b0;
            end else if (mem_valid) begin
                cnt       = 0;
                mem_valid = 1'b0;
            end else if (cnt == mem_lat - 1) begin
                mem_valid = 1'b1;
                mem_data  = mem[mem_addr];
            end else begin
                cnt = cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_issue(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'b0, instr_valid}, 32'd1);
    endtask

    // Called at a negedge in ISSUE; returns at the negedge after the retire edge
    task automatic retire_instr(input logic ld, input logic [7:0] val);
        done        = 1'b1;
        pc_load     = ld;
        pc_load_val = val;
        @(negedge clk);
        done        = 1'b0;
        pc_load     = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pc"},      {24'b0, pc},        32'h0);
        check_eq({tag, "_instr"},   {22'b0, instr},     32'h380);
        check_eq({tag, "_flags"},   {26'b0, mem_rd, instr_valid, busy, halted, fault, 1'b0}, 32'h0);
        check_eq({tag, "_retired"}, {16'b0, retired},   32'h0);
    endtask

    initial begin
        int iv_seen;
        int n;
        n_checks    = 0;
        n_pass      = 0;
        mem_lat     = 2;
        rst         = 1'b1;
        run         = 1'b0;
        halt_req    = 1'b0;
        done        = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        for (int i = 0; i < 256; i++) mem[i] = 10'h3C0;
        mem[8'h00] = 10'h049;
        mem[8'h01] = 10'h0C2;
        mem[8'h40] = 10'h009;
        mem[8'h41] = 10'h1C0;
        mem[8'h42] = 10'h3C0;
        mem[8'hFE] = 10'h049;
        mem[8'hFF] = 10'h089;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // run together with halt_req keeps the block idle
        run      = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        run      = 1'b0;
        halt_req = 1'b0;
        check_eq("idle_run_and_halt", {30'b0, busy, mem_rd}, 32'h0);

        // first instruction: LOAD R1 at address 0
        pulse_run();
        check_eq("fetch_addr0", {23'b0, mem_rd, mem_addr}, 32'h100);
        wait_issue("issue_0");
        check_eq("instr_0", {22'b0, instr}, 32'h049);
        retire_instr(1'b0, 8'h00);
        check_eq("retire0_pc", {24'b0, pc}, 32'h01);
        check_eq("retire0_cnt", {16'b0, retired}, 32'd1);
        check_eq("retire0_nop", {21'b0, instr_valid, instr}, 32'h380);
        check_eq("retire0_mem_rd", {31'b0, mem_rd}, 32'd1);

        // pc_load while fetching has no effect
        pc_load     = 1'b1;
        pc_load_val = 8'h77;
        @(negedge clk);
        pc_load     = 1'b0;
        check_eq("fetch_pc_load_ignored", {24'b0, pc}, 32'h01);
        wait_issue("issue_1");
        check_eq("instr_1", {22'b0, instr}, 32'h0C2);
        retire_instr(1'b1, 8'h40);
        check_eq("jump_mem_addr", {24'b0, mem_addr}, 32'h40);
        check_eq("jump_cnt", {16'b0, retired}, 32'd2);

        // executable at 0x40, undefined at 0x41 skipped, HALT at 0x42
        wait_issue("issue_40");
        check_eq("instr_40", {22'b0, instr}, 32'h009);
        retire_instr(1'b0, 8'h00);
        iv_seen = 0;
        n = 0;
        while (!halted && n < 40) begin
            @(negedge clk);
            if (instr_valid) iv_seen++;
            n++;
        end
        check_eq("skip_halted", {31'b0, halted}, 32'd1);
        check_eq("skip_pc", {24'b0, pc}, 32'h42);
        check_eq("skip_cnt", {16'b0, retired}, 32'd3);
        check_eq("skip_no_issue", iv_seen, 32'd0);

        // resume at 0x42, halt request mid-issue stops after retire
        mem[8'h42] = 10'h0D3;
        mem[8'h43] = 10'h049;
        pulse_run();
        check_eq("resume_addr", {23'b0, mem_rd, mem_addr}, 32'h142);
        wait_issue("issue_42");
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check_eq("halt_req_still_issuing", {30'b0, instr_valid, halted}, 32'h2);
        retire_instr(1'b0, 8'h00);
        check_eq("halt_req_halted", {31'b0, halted}, 32'd1);
        check_eq("halt_req_pc", {24'b0, pc}, 32'h43);
        check_eq("halt_req_cnt", {16'b0, retired}, 32'd4);

        // run to the end address and wrap
        pulse_run();
        wait_issue("issue_43");
        retire_instr(1'b1, 8'hFE);
        wait_issue("issue_fe");
        retire_instr(1'b0, 8'h00);
        check_eq("pre_end_pc", {24'b0, pc}, 32'hFF);
        check_eq("pre_end_busy", {30'b0, busy, halted}, 32'h2);
        wait_issue("issue_ff");
        check_eq("instr_ff", {22'b0, instr}, 32'h089);
        retire_instr(1'b0, 8'h00);
        check_eq("end_halted", {31'b0, halted}, 32'd1);
        check_eq("end_pc_wrap", {24'b0, pc}, 32'h00);
        check_eq("end_cnt", {16'b0, retired}, 32'd7);
        pulse_run();
        check_eq("end_resume", {23'b0, mem_rd, mem_addr}, 32'h100);

        // watchdog: withhold done for 15 issue cycles
        wait_issue("issue_wd");
        repeat (14) @(negedge clk);
        check_eq("wd_cycle15", {30'b0, fault, instr_valid}, 32'h1);
        @(negedge clk);
        check_eq("wd_fault", {29'b0, fault, instr_valid, busy}, 32'h4);
        pulse_run();
        check_eq("wd_run_ignored", {23'b0, fault, pc}, 32'h100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("fault_reset");

        // done and pc_load while idle are ignored
        done        = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 8'h55;
        @(negedge clk);
        done        = 1'b0;
        pc_load     = 1'b0;
        check_eq("idle_done_pc", {24'b0, pc}, 32'h00);
        check_eq("idle_done_cnt", {16'b0, retired}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
